mdio_phy_responder: RTL

- Clause-22 MDIO management responder: the PHY-side end of the management interface that the SoC drives as master (enet_mdc / enet_mdio).
- Holds a 32x16 PHY register file, decodes read and write frames, and drives read data back on MDIO.
- Used as a synthesizable PHY management model in loopback builds and as the bench responder for the SoC's MDIO master.
- Runs entirely in the wb_clk domain and oversamples MDC.

---
 rtl/mdio_pkg.sv | 33 +++
 rtl/mdio_sync_edge.sv | 34 +++
 rtl/mdio_phy_responder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared constants for the Clause-22 MDIO PHY responder: field widths, opcodes and FSM states.
package mdio_pkg;

    localparam int unsigned PHYAD_W   = 5;
    localparam int unsigned REGAD_W   = 5;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = PHYAD_W + REGAD_W;
    localparam int unsigned SKIP_BITS = 18;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned PRE_CNT_W = 6;
    localparam int unsigned BIT_CNT_W = 5;
    localparam int unsigned PRE_MAX   = 32;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [STATE_W-1:0] S_PRE     = 4'd0;
    localparam logic [STATE_W-1:0] S_ST1     = 4'd1;
    localparam logic [STATE_W-1:0] S_OP      = 4'd2;
    localparam logic [STATE_W-1:0] S_ADDR    = 4'd3;
    localparam logic [STATE_W-1:0] S_TA_RD   = 4'd4;
    localparam logic [STATE_W-1:0] S_TA_WR   = 4'd5;
    localparam logic [STATE_W-1:0] S_DATA_RD = 4'd6;
    localparam logic [STATE_W-1:0] S_DATA_WR = 4'd7;
    localparam logic [STATE_W-1:0] S_SKIP    = 4'd8;

    // PHY identifier registers ignore management writes.
    function automatic logic is_read_only(input logic [REGAD_W-1:0] regad);
        return (regad == 5'd2) || (regad == 5'd3);
    endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Brings MDC/MDIO into the wb_clk domain and turns each MDC rising edge into a one-cycle bit_en.
module mdio_sync_edge
    import mdio_pkg::*;
(
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic bit_en,
    output logic mdio_s
);

    logic [1:0] mdc_sync;
    logic [1:0] mdio_sync;
    logic       mdc_prev;

    // mdio_s is delayed alongside bit_en so the sampled bit lines up with its strobe.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            mdc_sync  <= 2'b00;
            mdio_sync <= 2'b00;
            mdc_prev  <= 1'b0;
            bit_en    <= 1'b0;
            mdio_s    <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[0], mdc_i};
            mdio_sync <= {mdio_sync[0], mdio_i};
            mdc_prev  <= mdc_sync[1];
            bit_en    <= mdc_sync[1] & ~mdc_prev;
            mdio_s    <= mdio_sync[1];
        end
    end

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder with a 32x16 register file, oversampling MDC in wb_clk.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1622,
    parameter logic [15:0] BMCR_RST     = 16'h1140,
    parameter logic [15:0] BMSR_RST     = 16'h796D,
    parameter int unsigned MIN_PREAMBLE = 32
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [4:0]  phy_addr_i,
    output logic        wr_stb_o,
    output logic [4:0]  wr_addr_o,
    output logic [15:0] wr_data_o
);

    logic                 bit_en;
    logic                 mdio_s;

    logic [STATE_W-1:0]   state, state_nxt;
    logic [PRE_CNT_W-1:0] pre_cnt, pre_cnt_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;

    logic [1:0]           op_sr;
    logic [ADDR_W-2:0]    addr_sr;
    logic [DATA_W-1:0]    data_sr;
    logic                 bad;
    logic [DATA_W-1:0]    regs [NUM_REGS];

    logic [1:0]           op_full;
    logic [ADDR_W-1:0]    addr_full;
    logic [DATA_W-1:0]    data_full;
    logic [REGAD_W-1:0]   regad;
    logic                 oe_nxt, o_nxt;
    logic                 commit, load_rd, shift_rd, ta_bad;

    mdio_sync_edge u_sync (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .mdc_i  (mdc_i),
        .mdio_i (mdio_i),
        .bit_en (bit_en),
        .mdio_s (mdio_s)
    );

    function automatic logic [DATA_W-1:0] reg_rst(input logic [REGAD_W-1:0] idx);
        case (idx)
            5'd0:    return BMCR_RST;
            5'd1:    return BMSR_RST;
            5'd2:    return PHY_ID1;
            5'd3:    return PHY_ID2;
            default: return '0;
        endcase
    endfunction

    assign op_full   = {op_sr[0], mdio_s};
    assign addr_full = {addr_sr, mdio_s};
    assign data_full = {data_sr[DATA_W-2:0], mdio_s};
    assign regad     = addr_sr[REGAD_W-1:0];

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state   <= S_PRE;
            pre_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pre_cnt <= pre_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Frame decoder: every transition is qualified by bit_en.
    always_comb begin
        state_nxt   = state;
        pre_cnt_nxt = pre_cnt;
        bit_cnt_nxt = bit_cnt;
        oe_nxt      = mdio_oe;
        o_nxt       = mdio_o;
        commit      = 1'b0;
        load_rd     = 1'b0;
        shift_rd    = 1'b0;
        ta_bad      = 1'b0;
        if (bit_en) begin
            case (state)
                S_PRE: begin
                    if (mdio_s) begin
                        if (pre_cnt != PRE_CNT_W'(PRE_MAX)) pre_cnt_nxt = pre_cnt + 6'd1;
                    end else if (pre_cnt >= PRE_CNT_W'(MIN_PREAMBLE)) begin
                        state_nxt = S_ST1;
                    end else begin
                        pre_cnt_nxt = '0;
                    end
                end
                S_ST1: begin
                    bit_cnt_nxt = '0;
                    if (mdio_s) begin
                        state_nxt = S_OP;
                    end else begin
                        state_nxt   = S_PRE;
                        pre_cnt_nxt = '0;
                    end
                end
                S_OP: begin
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd1) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = (op_full == OP_READ || op_full == OP_WRITE) ? S_ADDR : S_SKIP;
                    end
                end
                S_ADDR: begin
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == BIT_CNT_W'(ADDR_W - 1)) begin
                        bit_cnt_nxt = '0;
                        if (addr_full[ADDR_W-1:REGAD_W] != phy_addr_i) begin
                            state_nxt = S_SKIP;
                        end else if (op_sr == OP_READ) begin
                            state_nxt = S_TA_RD;
                            load_rd   = 1'b1;
                        end else begin
                            state_nxt = S_TA_WR;
                        end
                    end
                end
                S_TA_RD: begin
                    oe_nxt      = 1'b1;
                    o_nxt       = 1'b0;
                    bit_cnt_nxt = '0;
                    state_nxt   = S_DATA_RD;
                end
                S_DATA_RD: begin
                    // Sixteen shifts drive D15..D0; the seventeenth strobe releases the pad.
                    if (bit_cnt == BIT_CNT_W'(DATA_W)) begin
                        oe_nxt      = 1'b0;
                        o_nxt       = 1'b0;
                        state_nxt   = S_PRE;
                        pre_cnt_nxt = '0;
                    end else begin
                        o_nxt       = data_sr[DATA_W-1];
                        shift_rd    = 1'b1;
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
                S_TA_WR: begin
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd0) begin
                        ta_bad = ~mdio_s;
                    end else begin
                        ta_bad      = mdio_s;
                        bit_cnt_nxt = '0;
                        state_nxt   = S_DATA_WR;
                    end
                end
                S_DATA_WR: begin
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
                        commit      = ~bad & ~is_read_only(regad);
                        state_nxt   = S_PRE;
                        pre_cnt_nxt = '0;
                    end
                end
                S_SKIP: begin
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == BIT_CNT_W'(SKIP_BITS - 1)) begin
                        state_nxt   = S_PRE;
                        pre_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt   = S_PRE;
                    pre_cnt_nxt = '0;
                    oe_nxt      = 1'b0;
                    o_nxt       = 1'b0;
                end
            endcase
        end
    end

    // Shift registers, register file and registered outputs.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            mdio_oe   <= 1'b0;
            mdio_o    <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            op_sr     <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            bad       <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= reg_rst(REGAD_W'(i));
            end
        end else begin
            mdio_oe  <= oe_nxt;
            mdio_o   <= o_nxt;
            wr_stb_o <= commit;
            if (bit_en) begin
                case (state)
                    S_ST1:     bad     <= 1'b0;
                    S_OP:      op_sr   <= op_full;
                    S_ADDR:    addr_sr <= addr_full[ADDR_W-2:0];
                    S_TA_WR:   if (ta_bad) bad <= 1'b1;
                    S_DATA_WR: data_sr <= data_full;
                    default:   ;
                endcase
            end
            if (load_rd) data_sr <= regs[addr_full[REGAD_W-1:0]];
            if (shift_rd) data_sr <= {data_sr[DATA_W-2:0], 1'b0};
            if (commit) begin
                regs[regad] <= data_full;
                wr_addr_o   <= regad;
                wr_data_o   <= data_full;
            end
        end
    end

endmodule
